// File: rtl/alu_multi.sv
// alu_multi: bus ALU with A/G register pair, registered {N,V,C,Z} flags and a tri-state result driver.
// Define ALU_MUL_EN to build the multi-cycle shift-add multiplier (op=111); otherwise op=111 is a no-op.
module alu_multi #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Ain,
    input  logic             Gin,
    input  logic             Gout,
    input  logic [2:0]       op,
    inout  wire  [WIDTH-1:0] buswires,
    output logic             busy,
    output logic [3:0]       flags
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] G;
    logic [WIDTH-1:0] res;
    logic             c;
    logic             v;
    op_e              opc;

    assign opc      = op_e'(op);
    assign buswires = Gout ? G : 'z;

    // Single-cycle result and carry/overflow for every op except MUL.
    always_comb begin
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (opc)
            OP_ADD: begin
                {c, res} = {1'b0, A} + {1'b0, buswires};
                v = (A[WIDTH-1] == buswires[WIDTH-1]) && (res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                // Top bit of the widened difference is the borrow.
                {c, res} = {1'b0, A} - {1'b0, buswires};
                v = (A[WIDTH-1] != buswires[WIDTH-1]) && (res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND: res = A & buswires;
            OP_OR:  res = A | buswires;
            OP_XOR: res = A ^ buswires;
            OP_SHL: begin
                res = {A[WIDTH-2:0], 1'b0};
                c   = A[WIDTH-1];
            end
            OP_SHR: begin
                res = {1'b0, A[WIDTH-1:1]};
                c   = A[0];
            end
            default: ;
        endcase
    end

`ifdef ALU_MUL_EN
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {S_IDLE, S_MUL} state_e;

    state_e             state;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    assign acc_next = acc + (mplier[0] ? mcand : '0);
`else
    assign busy = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            A     <= '0;
            G     <= '0;
            flags <= '0;
`ifdef ALU_MUL_EN
            state  <= S_IDLE;
            busy   <= 1'b0;
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
`endif
        end else begin
`ifdef ALU_MUL_EN
            if (state == S_MUL) begin
                acc    <= acc_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CW'(1);
                if (cnt == CW'(WIDTH - 1)) begin
                    G     <= acc_next[WIDTH-1:0];
                    flags <= {acc_next[WIDTH-1], 1'b0, |acc_next[2*WIDTH-1:WIDTH],
                              acc_next[WIDTH-1:0] == '0};
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            end else
`endif
            if (Ain) begin
                A <= buswires;
            end else if (Gin) begin
                if (opc != OP_MUL) begin
                    G     <= res;
                    flags <= {res[WIDTH-1], v, c, res == '0};
                end
`ifdef ALU_MUL_EN
                else begin
                    mcand  <= {{WIDTH{1'b0}}, A};
                    mplier <= buswires;
                    acc    <= '0;
                    cnt    <= '0;
                    busy   <= 1'b1;
                    state  <= S_MUL;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_multi.sv
// Directed scoreboard bench for alu_multi (WIDTH=8); G is observed through the bus with Gout=1.
// Multiplier checks are built when ALU_MUL_EN is defined, the no-op MUL behaviour otherwise.
module tb_alu_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic       Ain;
    logic       Gin;
    logic       Gout;
    logic [2:0] op;
    logic       bus_en;
    logic [7:0] bus_drv;
    wire  [7:0] buswires;
    logic       busy;
    logic [3:0] flags;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] g;
        logic [3:0] f;
        string      tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    assign buswires = bus_en ? bus_drv : 8'hzz;

    alu_multi #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .Ain      (Ain),
        .Gin      (Gin),
        .Gout     (Gout),
        .op       (op),
        .buswires (buswires),
        .busy     (busy),
        .flags    (flags)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_g(input logic [7:0] g, input logic [3:0] f, input string tag);
        exp_t e;
        e.g   = g;
        e.f   = f;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Pop the oldest expectation and compare it with G (via the bus) and the flags.
    task automatic check_g();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard: observed=empty expected=entry");
        end else begin
            e      = sb.pop_front();
            bus_en = 1'b0;
            Gout   = 1'b1;
            #1;
            chk({e.tag, " G"}, buswires, e.g);
            chk({e.tag, " flags"}, {4'b0, flags}, {4'b0, e.f});
            Gout = 1'b0;
            #1;
        end
    endtask

    task automatic load_a(input logic [7:0] val);
        bus_en  = 1'b1;
        bus_drv = val;
        Ain     = 1'b1;
        tick();
        Ain    = 1'b0;
        bus_en = 1'b0;
    endtask

    task automatic alu_op(input logic [2:0] o, input logic [7:0] b,
                          input logic [7:0] g, input logic [3:0] f, input string tag);
        expect_g(g, f, tag);
        bus_en  = 1'b1;
        bus_drv = b;
        op      = o;
        Gin     = 1'b1;
        tick();
        Gin    = 1'b0;
        bus_en = 1'b0;
        check_g();
    endtask

`ifdef ALU_MUL_EN
    task automatic mul_run(input logic [7:0] b, input logic [7:0] g, input logic [3:0] f,
                           input string tag, input bit inject, input logic [7:0] old_g);
        int n;
        expect_g(g, f, tag);
        bus_en  = 1'b1;
        bus_drv = b;
        op      = 3'b111;
        Gin     = 1'b1;
        tick();
        Gin    = 1'b0;
        bus_en = 1'b0;
        n      = 0;
        while (busy === 1'b1 && n < 20) begin
            if (n == 2) begin
                Gout = 1'b1;
                #1;
                chk({tag, " G while busy"}, buswires, old_g);
                Gout = 1'b0;
                #1;
            end
            if (inject && n == 3) begin
                bus_en  = 1'b1;
                bus_drv = 8'hAA;
                Ain     = 1'b1;
                Gin     = 1'b1;
                op      = 3'b000;
            end else begin
                bus_en = 1'b0;
                Ain    = 1'b0;
                Gin    = 1'b0;
                op     = 3'b111;
            end
            n++;
            tick();
        end
        bus_en = 1'b0;
        Ain    = 1'b0;
        Gin    = 1'b0;
        chk({tag, " busy cycles"}, 8'(n), 8'd8);
        check_g();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        Ain     = 1'b0;
        Gin     = 1'b0;
        Gout    = 1'b0;
        op      = 3'b000;
        bus_en  = 1'b0;
        bus_drv = 8'h00;
        tick();
        tick();
        rst = 1'b0;

        chk("reset busy", {7'b0, busy}, 8'h00);
        chk("reset flags", {4'b0, flags}, 8'h00);
        expect_g(8'h00, 4'b0000, "reset");
        check_g();

        load_a(8'h7F);
        alu_op(3'b000, 8'h01, 8'h80, 4'b1100, "add ovf");
        load_a(8'h00);
        alu_op(3'b001, 8'h01, 8'hFF, 4'b1010, "sub borrow");
        load_a(8'hFF);
        alu_op(3'b000, 8'h01, 8'h00, 4'b0011, "add carry");
        load_a(8'h80);
        alu_op(3'b001, 8'h01, 8'h7F, 4'b0100, "sub ovf");

        load_a(8'h81);
        alu_op(3'b101, 8'hFF, 8'h02, 4'b0010, "shl");
        alu_op(3'b110, 8'h00, 8'h40, 4'b0010, "shr");

        load_a(8'hF0);
        alu_op(3'b010, 8'h0F, 8'h00, 4'b0001, "and");
        alu_op(3'b011, 8'h0F, 8'hFF, 4'b1000, "or");
        alu_op(3'b100, 8'hFF, 8'h0F, 4'b0000, "xor");

        // Ain and Gin together: only A loads.
        expect_g(8'h0F, 4'b0000, "ain+gin");
        bus_en  = 1'b1;
        bus_drv = 8'h55;
        op      = 3'b000;
        Ain     = 1'b1;
        Gin     = 1'b1;
        tick();
        Ain    = 1'b0;
        Gin    = 1'b0;
        bus_en = 1'b0;
        check_g();
        alu_op(3'b000, 8'h22, 8'h77, 4'b0000, "add after ain+gin");

        // A loaded from G through the bus.
        Gout = 1'b1;
        Ain  = 1'b1;
        tick();
        Ain  = 1'b0;
        Gout = 1'b0;
        alu_op(3'b110, 8'h00, 8'h3B, 4'b0010, "shr after A=G");

`ifdef ALU_MUL_EN
        load_a(8'h0C);
        mul_run(8'h0B, 8'h84, 4'b1000, "mul 0C*0B", 1'b0, 8'h3B);
        load_a(8'h10);
        mul_run(8'h10, 8'h00, 4'b0011, "mul 10*10", 1'b1, 8'h84);
        alu_op(3'b101, 8'h00, 8'h20, 4'b0000, "shl after mul");

        load_a(8'h0C);
        bus_en  = 1'b1;
        bus_drv = 8'h0B;
        op      = 3'b111;
        Gin     = 1'b1;
        tick();
        Gin    = 1'b0;
        bus_en = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst mid-mul busy", {7'b0, busy}, 8'h00);
        expect_g(8'h00, 4'b0000, "rst mid-mul");
        check_g();
        tick();
        chk("rst mid-mul busy later", {7'b0, busy}, 8'h00);
`else
        expect_g(8'h3B, 4'b0010, "mul disabled");
        bus_en  = 1'b1;
        bus_drv = 8'h0B;
        op      = 3'b111;
        Gin     = 1'b1;
        tick();
        Gin    = 1'b0;
        bus_en = 1'b0;
        chk("mul disabled busy", {7'b0, busy}, 8'h00);
        check_g();
        alu_op(3'b000, 8'h01, 8'h78, 4'b0000, "add after mul no-op");

        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst busy", {7'b0, busy}, 8'h00);
        expect_g(8'h00, 4'b0000, "rst");
        check_g();
`endif

        load_a(8'h03);
        alu_op(3'b000, 8'h04, 8'h07, 4'b0000, "add after rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_multi.md
Name: alu_multi

Overview:
- Parametrised, next-generation bus ALU for the simple-CPU datapath.
- Keeps the A/G register pair and the tri-state shared bus.
- Width is generic, with eight operations selected by an opcode, a registered flag set, and a multi-cycle shift-add multiplier with a busy indication.
- Sits on the processor bus beside the register file; the control FSM drives Ain/Gin/Gout/op.

Parameters:
- WIDTH, 8, data width of A, G, bus and result.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- Ain  input  1  load A from buswires.
- Gin  input  1  start operation op; result goes to G.
- Gout  input  1  drive G onto buswires; high-Z otherwise.
- op  input  3  operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
- buswires  inout  WIDTH  shared tri-state data bus; operand B source.
- busy  output  1  multiply in progress.
- flags  output  4  {N,V,C,Z} of last result written to G.

Behaviour:
- Reset (rst=1 at edge): A=0, G=0, flags=0, busy=0, FSM=IDLE. Overrides every other input and aborts any multiply in progress.
- buswires = G when Gout=1, else all Z. Gout is honoured in every state, including while busy; the old G is driven.
- FSM states: IDLE and MUL.
- IDLE, Ain=1: A <= buswires. Ain has priority: with Ain=Gin=1, only A loads and Gin is dropped.
- IDLE, Gin=1, Ain=0, op!=MUL: G <= f(A, B=buswires) and flags are updated on the same edge (1-cycle latency).
- ADD: G = A+B; C = carry out; V = signed overflow.
- SUB: G = A-B; C = borrow (1 when A<B unsigned); V = signed overflow.
- AND/OR/XOR: bitwise; C=0, V=0.
- SHL: G = A<<1; C = A[WIDTH-1]; V=0. B is ignored.
- SHR (logical): G = A>>1; C = A[0]; V=0. B is ignored.
- All ops: Z = (G==0); N = G[WIDTH-1]; results truncated to WIDTH.
- IDLE, Gin=1, Ain=0, op=MUL: capture multiplicand=A and multiplier=B; clear the 2*WIDTH accumulator and counter; busy<=1; go to MUL.
- MUL state, one multiplier bit per cycle (LSB first):
  - If the current multiplier bit is 1, add the shifted multiplicand into the accumulator.
  - Shift the multiplicand left and the multiplier right; increment the counter.
- On the WIDTH-th MUL edge:
  - G <= acc[WIDTH-1:0].
  - C = (acc[2*WIDTH-1:WIDTH] != 0); V=0; Z and N as above.
  - busy<=0; return to IDLE.
- MUL timing: busy is high for exactly WIDTH cycles; G is valid after WIDTH edges counted from the Gin edge.
- While busy: Ain, Gin and op are ignored; A and G stay unchanged until completion. op is sampled only on the Gin edge.
- Ain with Gout in the same cycle is legal (A <= G). Bus contention with other drivers is the controller's responsibility.
- flags change only when G is written.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: MUL behaves as above.
- Undefined: no multiplier logic is built; busy is tied to 0; op=111 with Gin is a no-op (G and flags unchanged, stays IDLE).

Test Plan (WIDTH=8):
- Reset/bus: rst, then Gout=1 -> buswires=0x00, flags=0, busy=0. Gout=0 -> buswires all Z.
- Load A=0x7F; Gin with op=ADD, bus=0x01 -> G=0x80, flags N=1 V=1 C=0 Z=0. Then op=SUB with A=0x00, bus=0x01 -> G=0xFF, C=1, N=1.
- A=0x81: op=SHL -> G=0x02, C=1. op=SHR -> G=0x40, C=1. A=0xF0, op=AND with bus=0x0F -> G=0x00, Z=1, C=0.
- A=0x0C, op=MUL, bus=0x0B:
  - busy high for 8 cycles; G=0x84 on the 8th edge with C=0.
  - A=0x10, bus=0x10 -> G=0x00, C=1, Z=1.
  - Assert Ain/Gin mid-multiply -> ignored.
- Simultaneous Ain=Gin=1 in IDLE with bus=0x55 -> A=0x55, G and flags unchanged.
- rst asserted at multiply cycle 4 -> next edge busy=0, G=0, IDLE. A new ADD afterwards works. With ALU_MUL_EN undefined, op=MUL leaves G unchanged and busy=0.
